// File: rtl/vga_sram_pkg.sv
// Shared constants and types for the VGA frame writer and scan-out reader.
// Holds the active-area size, the SRAM bus widths, the writer state encoding
// and the RGB565 pixel layout.
package vga_sram_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned SRAM_ADDR_W  = 20;
    localparam int unsigned SRAM_DATA_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_SETUP = 3'd2,
        S_WRITE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } writer_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/sram_frame_writer.sv
// Writes one RGB565 frame, raster order, into a 16-bit asynchronous SRAM.
// Each pixel takes a SETUP cycle (address/data settle, WE_N high) and a WRITE
// cycle (WE_N low), so the steady rate is one pixel per two clocks.
//
// Ports:
//   i_50M_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start, i_abort           arm one frame capture / abandon and release bus
//   i_pix_data/valid/sof       pixel stream, sof marks pixel (0,0)
//   o_pix_ready                pixel accepted on valid && ready
//   o_SRAM_*                   SRAM address, data and active-low strobes
//   o_bus_req, o_busy          bus ownership, state != S_IDLE
//   o_resync, o_frame_done     1-cycle pulses: mid-frame SOF, frame stored
//   o_checksum                 sum of words written since the last SOF
//
// Build option: define SRAM_FRAME_WRITER_CHECKSUM_EN to build the checksum
// adder; otherwise o_checksum is tied to zero.
module sram_frame_writer
    import vga_sram_pkg::*;
#(
    parameter int unsigned       H_ACTIVE  = VGA_H_ACTIVE,
    parameter int unsigned       V_ACTIVE  = VGA_V_ACTIVE,
    parameter int unsigned       ADDR_W    = SRAM_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                   i_50M_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [SRAM_DATA_W-1:0] i_pix_data,
    input  logic                   i_pix_valid,
    input  logic                   i_pix_sof,
    output logic                   o_pix_ready,
    output logic [ADDR_W-1:0]      o_SRAM_address,
    output logic [SRAM_DATA_W-1:0] o_SRAM_wdata,
    output logic                   o_SRAM_we_n,
    output logic                   o_SRAM_oe_n,
    output logic                   o_SRAM_ce_n,
    output logic                   o_SRAM_lb_n,
    output logic                   o_SRAM_ub_n,
    output logic                   o_bus_req,
    output logic                   o_busy,
    output logic                   o_resync,
    output logic                   o_frame_done,
    output logic [SRAM_DATA_W-1:0] o_checksum
);

    localparam int unsigned       N     = H_ACTIVE * V_ACTIVE;
    localparam int unsigned       CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N - 1);

    writer_state_t          state, state_n;
    logic [CNT_W-1:0]       count, count_n;
    logic [ADDR_W-1:0]      addr_n;
    logic [SRAM_DATA_W-1:0] wdata_n;
    logic                   accept;
    logic                   load;
    logic                   resync_n;
    logic                   ready_n;
    logic                   bus_n;
    logic                   we_low_n;
    logic                   done_n;

    assign accept = i_pix_valid && o_pix_ready;

    // Next state, counter, pixel latch and registered-output decode.
    always_comb begin
        state_n  = state;
        count_n  = count;
        load     = 1'b0;
        resync_n = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (i_start) state_n = S_ARM;
            end
            S_ARM: begin
                // Non-SOF pixels are accepted here only to be discarded.
                if (accept && i_pix_sof) begin
                    load    = 1'b1;
                    count_n = '0;
                    state_n = S_SETUP;
                end
            end
            S_SETUP: begin
                state_n = S_WRITE;
            end
            S_WRITE, S_WAIT: begin
                if (state == S_WRITE && count == LAST) begin
                    state_n = S_DONE;
                end else if (accept) begin
                    load    = 1'b1;
                    state_n = S_SETUP;
                    if (i_pix_sof) begin
                        count_n  = '0;
                        resync_n = 1'b1;
                    end else begin
                        count_n = count + CNT_W'(1);
                    end
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_DONE: begin
                count_n = '0;
                state_n = S_IDLE;
            end
            default: begin
                count_n = '0;
                state_n = S_IDLE;
            end
        endcase

        // Abort wins; address/data are left untouched so no WE_N-low edge
        // sees them move.
        if (i_abort) begin
            state_n  = S_IDLE;
            count_n  = '0;
            load     = 1'b0;
            resync_n = 1'b0;
        end

        addr_n  = load ? BASE_ADDR + ADDR_W'(count_n) : o_SRAM_address;
        wdata_n = load ? i_pix_data : o_SRAM_wdata;

        // Outputs are decoded from the next state and registered.
        ready_n  = (state_n == S_ARM) || (state_n == S_WAIT) ||
                   (state_n == S_WRITE && count_n != LAST);
        bus_n    = (state_n == S_SETUP) || (state_n == S_WRITE) || (state_n == S_WAIT);
        we_low_n = (state_n == S_WRITE);
        done_n   = (state_n == S_DONE);
    end

    // State, counter and output registers.
    always_ff @(posedge i_50M_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_IDLE;
            count          <= '0;
            o_SRAM_address <= BASE_ADDR;
            o_SRAM_wdata   <= '0;
            o_SRAM_we_n    <= 1'b1;
            o_SRAM_oe_n    <= 1'b1;
            o_SRAM_ce_n    <= 1'b1;
            o_SRAM_lb_n    <= 1'b1;
            o_SRAM_ub_n    <= 1'b1;
            o_bus_req      <= 1'b0;
            o_pix_ready    <= 1'b0;
            o_busy         <= 1'b0;
            o_resync       <= 1'b0;
            o_frame_done   <= 1'b0;
        end else begin
            state          <= state_n;
            count          <= count_n;
            o_SRAM_address <= addr_n;
            o_SRAM_wdata   <= wdata_n;
            o_SRAM_we_n    <= !we_low_n;
            o_SRAM_oe_n    <= 1'b1;
            o_SRAM_ce_n    <= !bus_n;
            o_SRAM_lb_n    <= !bus_n;
            o_SRAM_ub_n    <= !bus_n;
            o_bus_req      <= bus_n;
            o_pix_ready    <= ready_n;
            o_busy         <= (state_n != S_IDLE);
            o_resync       <= resync_n;
            o_frame_done   <= done_n;
        end
    end

`ifdef SRAM_FRAME_WRITER_CHECKSUM_EN
    logic [SRAM_DATA_W-1:0] checksum;
    logic                   sof_load;

    assign sof_load = load && i_pix_sof;

    // Clear on every accepted SOF (including resync); add each word as it is
    // strobed, so the total is complete in the S_DONE cycle.
    always_ff @(posedge i_50M_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            checksum <= '0;
        end else if (sof_load) begin
            checksum <= '0;
        end else if (state == S_WRITE) begin
            checksum <= checksum + o_SRAM_wdata;
        end
    end

    assign o_checksum = checksum;
`else
    assign o_checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_frame_writer.sv
// Scoreboard bench for sram_frame_writer with a 4x2 frame at base 0x100.
module tb_sram_frame_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] data = 16'h0;
    logic        valid = 1'b0;
    logic        sof = 1'b0;

    logic        pix_ready;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        we_n, oe_n, ce_n, lb_n, ub_n;
    logic        bus_req, busy, resync, frame_done;
    logic [15:0] checksum;

    sram_frame_writer #(
        .H_ACTIVE (4),
        .V_ACTIVE (2),
        .ADDR_W   (20),
        .BASE_ADDR(20'h00100)
    ) dut (
        .i_50M_clk     (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_abort       (abort),
        .i_pix_data    (data),
        .i_pix_valid   (valid),
        .i_pix_sof     (sof),
        .o_pix_ready   (pix_ready),
        .o_SRAM_address(sram_addr),
        .o_SRAM_wdata  (sram_wdata),
        .o_SRAM_we_n   (we_n),
        .o_SRAM_oe_n   (oe_n),
        .o_SRAM_ce_n   (ce_n),
        .o_SRAM_lb_n   (lb_n),
        .o_SRAM_ub_n   (ub_n),
        .o_bus_req     (bus_req),
        .o_busy        (busy),
        .o_resync      (resync),
        .o_frame_done  (frame_done),
        .o_checksum    (checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   writes = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   resync_cnt = 0;
    logic prev_we = 1'b1;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] ck_exp(input logic [15:0] s);
`ifdef SRAM_FRAME_WRITER_CHECKSUM_EN
        return s;
`else
        return 16'h0000 & s;
`endif
    endfunction

    // Monitor: every falling WE_N is one SRAM write, matched against the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_we && !we_n) begin
                writes++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h, required no write",
                             sram_addr, sram_wdata);
                end else begin
                    mon_e = q.pop_front();
                    chk("wr_addr", 32'(sram_addr), 32'(mon_e.a));
                    chk("wr_data", 32'(sram_wdata), 32'(mon_e.d));
                    chk("wr_strobes", {29'd0, ce_n, lb_n, ub_n}, 32'd0);
                end
            end
            if (prev_done) chk("done_width", 32'(frame_done), 32'd0);
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (resync) resync_cnt++;
        end
        prev_we   = we_n;
        prev_done = frame_done;
    end

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [15:0] d, input logic s);
        int n = 0;
        valid = 1'b1;
        data  = d;
        sof   = s;
        while (!pix_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready 0 for 50 cycles, required 1");
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic idle_in();
        valid = 1'b0;
        sof   = 1'b0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_count", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc_cyc;
        int          w0;
        logic [15:0] sum;

        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(sram_addr), 32'h100);
        chk("rst_wdata", 32'(sram_wdata), 32'h0);
        chk("rst_strobes", {27'd0, we_n, oe_n, ce_n, lb_n, ub_n}, 32'h1f);
        chk("rst_flags", {27'd0, bus_req, pix_ready, busy, resync, frame_done}, 32'h0);
        chk("rst_checksum", 32'(checksum), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // start together with abort in S_IDLE stays idle
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", {30'd0, busy, pix_ready}, 32'd0);

        // Test 1: back-to-back frame, timing and SOF on pixel N
        start_frame();
        chk("arm_flags", {28'd0, pix_ready, busy, bus_req, ce_n}, 32'b1101);
        sum = 16'h0;
        for (int i = 0; i < 8; i++) begin
            q.push_back({20'h100 + 20'(i), 16'h1000 + 16'(i)});
            sum = sum + 16'h1000 + 16'(i);
        end
        acc_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            send(16'h1000 + 16'(i), i == 0);
            if (i == 0) acc_cyc = cyc;
        end
        data  = 16'hDEAD;
        sof   = 1'b1;
        valid = 1'b1;
        @(negedge clk);
        chk("last_write_ready", {30'd0, pix_ready, we_n}, 32'd0);
        wait_done(1);
        idle_in();
        chk("sof_to_done_cycles", 32'(done_cyc - acc_cyc), 32'd16);
        @(negedge clk);
        chk("post_done_bus", {29'd0, bus_req, busy, ce_n}, 32'b001);
        chk("t1_checksum", 32'(checksum), 32'(ck_exp(sum)));
        chk("t1_queue_empty", 32'(q.size()), 32'd0);

        // Test 2: non-SOF pixels in S_ARM are dropped
        start_frame();
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b0);
        for (int i = 0; i < 8; i++) q.push_back({20'h100 + 20'(i), 16'(i + 1)});
        for (int i = 0; i < 8; i++) send(16'(i + 1), i == 0);
        idle_in();
        wait_done(2);
        chk("t2_checksum", 32'(checksum), 32'(ck_exp(16'h0024)));
        chk("t2_no_resync", 32'(resync_cnt), 32'd0);

        // Test 3: 5-cycle source stall after the third pixel
        w0 = writes;
        start_frame();
        for (int i = 0; i < 8; i++) q.push_back({20'h100 + 20'(i), 16'h3000 + 16'(i)});
        for (int i = 0; i < 3; i++) send(16'h3000 + 16'(i), i == 0);
        idle_in();
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("wait_state", {10'd0, sram_addr, pix_ready, ce_n}, {10'd0, 20'h102, 2'b10});
            chk("wait_we_n", 32'(we_n), 32'd1);
        end
        for (int i = 3; i < 8; i++) send(16'h3000 + 16'(i), 1'b0);
        idle_in();
        wait_done(3);
        chk("t3_write_total", 32'(writes - w0), 32'd8);

        // Test 4: SOF on the fifth pixel restarts the frame
        start_frame();
        for (int i = 0; i < 4; i++) q.push_back({20'h100 + 20'(i), 16'h4000 + 16'(i)});
        sum = 16'h0;
        for (int j = 0; j < 8; j++) begin
            q.push_back({20'h100 + 20'(j), 16'h5000 + 16'(j)});
            sum = sum + 16'h5000 + 16'(j);
        end
        for (int i = 0; i < 4; i++) send(16'h4000 + 16'(i), i == 0);
        for (int j = 0; j < 7; j++) send(16'h5000 + 16'(j), j == 0);
        chk("t4_no_early_done", 32'(done_cnt), 32'd3);
        send(16'h5007, 1'b0);
        idle_in();
        wait_done(4);
        chk("t4_resync_count", 32'(resync_cnt), 32'd1);
        chk("t4_checksum", 32'(checksum), 32'(ck_exp(sum)));

        // Test 5: abort during the write of the third pixel
        start_frame();
        for (int i = 0; i < 3; i++) q.push_back({20'h100 + 20'(i), 16'h6000 + 16'(i)});
        for (int i = 0; i < 3; i++) send(16'h6000 + 16'(i), i == 0);
        idle_in();
        @(negedge clk);
        chk("abort_in_write", 32'(we_n), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_release", {27'd0, busy, bus_req, pix_ready, ce_n, we_n}, 32'b00011);
        repeat (5) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'd4);

        // Test 6 (with Test 5 restart): 0x8000 x8 sums to zero
        start_frame();
        for (int i = 0; i < 8; i++) q.push_back({20'h100 + 20'(i), 16'h8000});
        for (int i = 0; i < 8; i++) send(16'h8000, i == 0);
        idle_in();
        wait_done(5);
        chk("t6_checksum", 32'(checksum), 32'h0);
        @(negedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        chk("final_bus_req", 32'(bus_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
